// File: rtl/vector_lsu.sv
// rtl/vector_lsu.sv - strided vector load/store unit with same-address write merging
module vector_lsu #(
    parameter int LANES  = 16,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_base,
    input  logic [ADDR_W-1:0]       req_stride,
    input  logic [LANES-1:0]        req_mask,
    input  logic [LANES*DATA_W-1:0] req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [LANES*DATA_W-1:0] resp_rdata,
    output logic                    mem_wren,
    output logic [31:0]             mem_a0,
    output logic [31:0]             mem_a1,
    output logic [31:0]             mem_a2,
    output logic [31:0]             mem_a3,
    output logic [31:0]             mem_a4,
    output logic [31:0]             mem_a5,
    output logic [31:0]             mem_a6,
    output logic [31:0]             mem_a7,
    output logic [31:0]             mem_a8,
    output logic [31:0]             mem_a9,
    output logic [31:0]             mem_a10,
    output logic [31:0]             mem_a11,
    output logic [31:0]             mem_a12,
    output logic [31:0]             mem_a13,
    output logic [31:0]             mem_a14,
    output logic [31:0]             mem_a15,
    output logic [LANES*DATA_W-1:0] mem_wdata,
    input  logic [LANES*DATA_W-1:0] mem_rdata
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;
    localparam int NPORTS = 16;

    logic [2:0]              state_q, state_d;
    logic                    we_q, we_d;
    logic [LANES-1:0]        mask_q, mask_d;
    logic [LANES*DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0]       addr_q [LANES];
    logic [ADDR_W-1:0]       addr_d [LANES];
    logic [LANES*DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LANES*DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [LANES*DATA_W-1:0] merged;
    logic [LANES*DATA_W-1:0] masked_load;

    // Every lane takes the data of the highest enabled lane sharing its address, else
    // writes back what it read, so colliding ports all carry identical data.
    always_comb begin
        merged      = '0;
        masked_load = '0;
        for (int i = 0; i < LANES; i++) begin
            masked_load[i*DATA_W +: DATA_W] = mask_q[i] ? mem_rdata[i*DATA_W +: DATA_W] : '0;
            merged[i*DATA_W +: DATA_W]      = mem_rdata[i*DATA_W +: DATA_W];
            for (int j = 0; j < LANES; j++) begin
                if (mask_q[j] && (addr_q[j] == addr_q[i])) begin
                    merged[i*DATA_W +: DATA_W] = wdata_q[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        mask_d       = mask_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    mask_d  = req_mask;
                    wdata_d = req_wdata;
                    for (int i = 0; i < LANES; i++) begin
                        addr_d[i] = req_base + ADDR_W'(i) * req_stride;
                    end
                    state_d = req_we ? S_MERGE : S_LOAD;
                end
            end
            S_LOAD: begin
                resp_rdata_d = masked_load;
                state_d      = S_RESP;
            end
            S_MERGE: begin
                mem_wdata_d  = merged;
                resp_rdata_d = merged;
                state_d      = S_WRITE;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            mask_q       <= '0;
            wdata_q      <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            mask_q       <= mask_d;
            wdata_q      <= wdata_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            addr_q       <= addr_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign mem_wren   = (state_q == S_WRITE) && !rst;
    assign mem_wdata  = mem_wdata_q;
    assign resp_rdata = resp_rdata_q;

    logic [31:0] mem_a_w [NPORTS];

    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        if (g < LANES) begin : g_used
            assign mem_a_w[g] = {{(32-ADDR_W){1'b0}}, addr_q[g]};
        end else begin : g_unused
            assign mem_a_w[g] = '0;
        end
    end

    assign mem_a0  = mem_a_w[0];
    assign mem_a1  = mem_a_w[1];
    assign mem_a2  = mem_a_w[2];
    assign mem_a3  = mem_a_w[3];
    assign mem_a4  = mem_a_w[4];
    assign mem_a5  = mem_a_w[5];
    assign mem_a6  = mem_a_w[6];
    assign mem_a7  = mem_a_w[7];
    assign mem_a8  = mem_a_w[8];
    assign mem_a9  = mem_a_w[9];
    assign mem_a10 = mem_a_w[10];
    assign mem_a11 = mem_a_w[11];
    assign mem_a12 = mem_a_w[12];
    assign mem_a13 = mem_a_w[13];
    assign mem_a14 = mem_a_w[14];
    assign mem_a15 = mem_a_w[15];
endmodule

// File: doc/vector_lsu.md
VECTOR_LSU -- requirements
Module: vector_lsu

Interface
REQ-001 The block SHALL have parameter LANES, default 16, meaning the number of vector lanes and memory address ports.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the lane width in bits.
REQ-003 The block SHALL have parameter ADDR_W, default 5, meaning the effective word-address width (32-entry memory).
REQ-004 clk  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  is the reset; it SHALL be synchronous and active-high.
REQ-006 req_valid  in  1  SHALL indicate a request is offered.
REQ-007 req_ready  out  1  SHALL indicate the block accepts a request.
REQ-008 req_we  in  1  SHALL select the operation: 1 = store, 0 = load.
REQ-009 req_base  in  ADDR_W  SHALL be the address of lane 0.
REQ-010 req_stride  in  ADDR_W  SHALL be the unsigned lane-to-lane address increment.
REQ-011 req_mask  in  LANES  SHALL be the per-lane enable; bit i enables lane i.
REQ-012 req_wdata  in  LANES*DATA_W  SHALL be the store data, with lane i at bits [16i+15:16i].
REQ-013 resp_valid  out  1  SHALL indicate a completed response.
REQ-014 resp_ready  in  1  SHALL indicate the consumer accepts the response.
REQ-015 resp_rdata  out  LANES*DATA_W  SHALL be the response data.
REQ-016 mem_wren  out  1  SHALL be the write enable to the vector memory.
REQ-017 mem_a0..mem_a15  out  32 each  SHALL be the per-lane word addresses to the vector memory; bits [31:ADDR_W] SHALL always be 0.
REQ-018 mem_wdata  out  LANES*DATA_W  SHALL be the write data to the vector memory.
REQ-019 mem_rdata  in  LANES*DATA_W  SHALL be the combinational read data returned from the vector memory.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD, MERGE, WRITE and RESP.
REQ-021 req_ready SHALL be 1 only in IDLE.
REQ-022 On an accepting edge (IDLE and req_valid), the block SHALL latch we, mask and wdata, and SHALL register mem_a_i = (req_base + i*req_stride) mod 2^ADDR_W.
REQ-023 After the accepting edge, the FSM SHALL go to LOAD if we=0 and to MERGE if we=1.
REQ-024 In LOAD, the block SHALL capture resp_rdata lane i = mem_rdata lane i if mask[i], else 0, and SHALL then go to RESP.
REQ-025 In MERGE, for each lane i, the block SHALL set mem_wdata lane i to wdata lane j, where j is the highest-index enabled lane with mem_a_j == mem_a_i, and SHALL go to WRITE.
REQ-026 In MERGE, if no enabled lane shares mem_a_i, the block SHALL set mem_wdata lane i to mem_rdata lane i (old value).
REQ-027 The rule in REQ-025/REQ-026 SHALL give all ports targeting the same address identical data, so memory write ordering is irrelevant.
REQ-028 In WRITE, mem_wren SHALL be 1 for exactly one cycle, then the FSM SHALL go to RESP.
REQ-029 For stores, resp_rdata SHALL equal the mem_wdata that was written.
REQ-030 mem_wren SHALL be 0 in every state except WRITE.
REQ-031 mem_wren SHALL be gated by ~rst (combinationally 0 whenever rst=1).
REQ-032 mem_a_* and mem_wdata SHALL hold their values from acceptance until the next acceptance.
REQ-033 Load latency SHALL be: resp_valid asserts 2 cycles after the accepting edge.
REQ-034 Store latency SHALL be: resp_valid asserts 3 cycles after the accepting edge.
REQ-035 In RESP, resp_valid SHALL stay 1 and resp_rdata SHALL stay stable until resp_ready=1.
REQ-036 On the edge where resp_valid and resp_ready are both 1, the FSM SHALL go to IDLE; a new request SHALL be accepted no earlier than the following edge.
REQ-037 A store with mask=0 SHALL still perform the WRITE cycle, writing back the old data, so memory is unchanged.
REQ-038 A load with mask=0 SHALL return all-zero data.
REQ-039 Address arithmetic SHALL wrap modulo 2^ADDR_W, including stride=0 (all lanes target base).

Reset
REQ-040 While rst=1 at an edge, the FSM SHALL go to IDLE and the outputs SHALL become req_ready=1, resp_valid=0, mem_wren=0, mem_a_*=0, mem_wdata=0 and resp_rdata=0.
REQ-041 Reset asserted in any state, including WRITE, SHALL abort the operation with no memory write and no response.

Verification
REQ-042 Reset test: rst high for 2 cycles -> req_ready=1, resp_valid=0, mem_wren=0, all mem_a_i=0.
REQ-043 Unit-stride store/load test: store base=0, stride=1, mask=0xFFFF, lane i=0x1000+i -> one mem_wren pulse at cycle 2 and resp_valid at cycle 3; then load base=0, stride=1 -> resp_rdata lane i=0x1000+i at cycle 2.
REQ-044 Wrap-around test: load base=30, stride=1 -> mem_a0=30, mem_a1=31, mem_a2=0, ..., mem_a15=13.
REQ-045 Masked-store test: store mask=0x0005, base=4, stride=2, all lanes data 0xAAAA -> only addresses 4 and 8 become 0xAAAA; a full load confirms all other words are unchanged.
REQ-046 Duplicate-address test: store stride=0, base=7, mask=0x0003, lane0=0x1111, lane1=0x2222 -> all 16 mem_wdata lanes=0x2222 and RAM[7]=0x2222.
REQ-047 Backpressure and mid-operation reset test: resp_ready held low for 5 cycles -> resp_valid and resp_rdata stay stable; rst asserted during WRITE -> mem_wren=0 in that cycle, memory unchanged, FSM in IDLE.
